ldpc_3gpp_dec_obuf_ctrl: RTL and testbench

Ping-pong controller for the two-bank decoded-bit RAM that the decoder engine sink writes into. It steers sink writes to the free bank, latches per-block context (length, tag, decfail, err) when the block completes, and sequences read-out of full banks to the user with sop/eop framing. Backpressure from the user stalls the whole read pipeline; backpressure to the engine is driven by ordy.

---
 rtl/ldpc_3gpp_dec_obuf_ctrl_if.sv | 37 +++
 rtl/ldpc_3gpp_dec_obuf_ctrl.sv | 156 +++++++++++++++
 tb/tb_ldpc_3gpp_dec_obuf_ctrl.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ldpc_3gpp_dec_obuf_ctrl_if.sv
// rtl/ldpc_3gpp_dec_obuf_ctrl_if.sv - sink-write and user-read signal bundle for the output buffer controller
interface ldpc_3gpp_dec_obuf_ctrl_if #(
  parameter int pADDR_W = 8,
  parameter int pTAG_W  = 4,
  parameter int pERR_W  = 16
) ();
  logic               iwrite;
  logic               iwfull;
  logic [pADDR_W-1:0] iwaddr;
  logic [pADDR_W:0]   ilen;
  logic [pTAG_W-1:0]  itag;
  logic               idecfail;
  logic [pERR_W-1:0]  ierr;
  logic               ordy;
  logic               owena;
  logic [pADDR_W:0]   owaddr;
  logic               oovf;
  logic               irdy;
  logic               oren;
  logic [pADDR_W:0]   oraddr;
  logic               oval;
  logic               osop;
  logic               oeop;
  logic [pTAG_W-1:0]  otag;
  logic               odecfail;
  logic [pERR_W-1:0]  oerr;

  modport slave (
    input  iwrite, iwfull, iwaddr, ilen, itag, idecfail, ierr, irdy,
    output ordy, owena, owaddr, oovf, oren, oraddr, oval, osop, oeop, otag, odecfail, oerr
  );

  modport master (
    output iwrite, iwfull, iwaddr, ilen, itag, idecfail, ierr, irdy,
    input  ordy, owena, owaddr, oovf, oren, oraddr, oval, osop, oeop, otag, odecfail, oerr
  );
endinterface

// File: rtl/ldpc_3gpp_dec_obuf_ctrl.sv
// rtl/ldpc_3gpp_dec_obuf_ctrl.sv - ping-pong bank controller for decoded-bit RAM with framed read-out
// Optional block statistics counters enabled by LDPC_3GPP_DEC_OBUF_STAT_EN.
module ldpc_3gpp_dec_obuf_ctrl #(
  parameter int pADDR_W = 8,
  parameter int pTAG_W  = 4,
  parameter int pERR_W  = 16,
  parameter int pRD_LAT = 2
) (
  input  logic iclk,
  input  logic ireset,
  input  logic iclkena,
  ldpc_3gpp_dec_obuf_ctrl_if.slave bus
`ifdef LDPC_3GPP_DEC_OBUF_STAT_EN
  ,
  output logic [15:0] ostat_blk,
  output logic [15:0] ostat_fail
`endif
);

  localparam int LEN_W = pADDR_W + 1;

  typedef struct packed {
    logic [LEN_W-1:0]  len;
    logic [pTAG_W-1:0] tag;
    logic              decfail;
    logic [pERR_W-1:0] err;
  } ctx_t;

  typedef struct packed {
    logic              val;
    logic              sop;
    logic              eop;
    logic [pTAG_W-1:0] tag;
    logic              decfail;
    logic [pERR_W-1:0] err;
  } pent_t;

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DRAIN} state_t;

  state_t             state_q, state_d;
  logic               wbank_q, rbank_q;
  logic [1:0]         full_q, full_d;
  logic [pADDR_W-1:0] rd_cnt_q, rd_cnt_d;
  ctx_t               ctx_q [2];
  pent_t              pipe_q [pRD_LAT];
  pent_t              pipe_in, pipe_out;
  logic               ovf_q;

  logic               wr_free, adv, blk_done, rd_free, last_word;
  ctx_t               rctx;
  logic [LEN_W-1:0]   len_eff;

  assign wr_free  = ~full_q[wbank_q];
  assign adv      = iclkena & bus.irdy;
  assign blk_done = iclkena & bus.iwrite & bus.iwfull & wr_free;
  assign pipe_out = pipe_q[pRD_LAT-1];
  assign rd_free  = adv & pipe_out.val & pipe_out.eop;
  assign rctx     = ctx_q[rbank_q];
  // A zero-length block is read out as a single word.
  assign len_eff   = (rctx.len == '0) ? LEN_W'(1) : rctx.len;
  assign last_word = ({1'b0, rd_cnt_q} == (len_eff - LEN_W'(1)));

  assign bus.ordy     = wr_free;
  assign bus.owena    = bus.iwrite & wr_free;
  assign bus.owaddr   = {wbank_q, bus.iwaddr};
  assign bus.oovf     = ovf_q;
  assign bus.oren     = adv;
  assign bus.oraddr   = {rbank_q, rd_cnt_q};
  assign bus.oval     = pipe_out.val;
  assign bus.osop     = pipe_out.sop;
  assign bus.oeop     = pipe_out.eop;
  assign bus.otag     = pipe_out.tag;
  assign bus.odecfail = pipe_out.decfail;
  assign bus.oerr     = pipe_out.err;

  always_comb begin
    full_d = full_q;
    if (rd_free) full_d[rbank_q] = 1'b0;
    if (blk_done) full_d[wbank_q] = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    pipe_in  = '0;
    case (state_q)
      ST_IDLE: begin
        if (full_q[rbank_q]) begin
          state_d  = ST_READ;
          rd_cnt_d = '0;
        end
      end
      ST_READ: begin
        pipe_in.val     = 1'b1;
        pipe_in.sop     = (rd_cnt_q == '0);
        pipe_in.eop     = last_word;
        pipe_in.tag     = rctx.tag;
        pipe_in.decfail = rctx.decfail;
        pipe_in.err     = rctx.err;
        if (last_word) state_d = ST_DRAIN;
        else rd_cnt_d = rd_cnt_q + pADDR_W'(1);
      end
      ST_DRAIN: begin
        if (rd_free) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state_q  <= ST_IDLE;
      wbank_q  <= 1'b0;
      rbank_q  <= 1'b0;
      full_q   <= 2'b00;
      rd_cnt_q <= '0;
      ovf_q    <= 1'b0;
      ctx_q[0] <= '0;
      ctx_q[1] <= '0;
      for (int i = 0; i < pRD_LAT; i++) pipe_q[i] <= '0;
    end else if (iclkena) begin
      full_q <= full_d;
      if (blk_done) begin
        ctx_q[wbank_q] <= {bus.ilen, bus.itag, bus.idecfail, bus.ierr};
        wbank_q        <= ~wbank_q;
      end
      if (bus.iwrite & ~wr_free) ovf_q <= 1'b1;
      if (rd_free) rbank_q <= ~rbank_q;
      // User backpressure freezes the FSM and the read pipe together.
      if (bus.irdy) begin
        state_q   <= state_d;
        rd_cnt_q  <= rd_cnt_d;
        pipe_q[0] <= pipe_in;
        for (int i = 1; i < pRD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

`ifdef LDPC_3GPP_DEC_OBUF_STAT_EN
  logic [15:0] stat_blk_q, stat_fail_q;

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      stat_blk_q  <= '0;
      stat_fail_q <= '0;
    end else if (rd_free) begin
      if (stat_blk_q != 16'hFFFF) stat_blk_q <= stat_blk_q + 16'd1;
      if (pipe_out.decfail && (stat_fail_q != 16'hFFFF)) stat_fail_q <= stat_fail_q + 16'd1;
    end
  end

  assign ostat_blk  = stat_blk_q;
  assign ostat_fail = stat_fail_q;
`endif

endmodule

// File: tb/tb_ldpc_3gpp_dec_obuf_ctrl.sv
// tb/tb_ldpc_3gpp_dec_obuf_ctrl.sv - self-checking bench for the ping-pong output buffer controller
module tb_ldpc_3gpp_dec_obuf_ctrl;
  localparam int AW  = 8;
  localparam int LW  = AW + 1;
  localparam int TW  = 4;
  localparam int EW  = 16;
  localparam int LAT = 2;

  logic iclk = 1'b0;
  logic ireset;
  logic iclkena;
  always #5 iclk = ~iclk;

  ldpc_3gpp_dec_obuf_ctrl_if #(.pADDR_W(AW), .pTAG_W(TW), .pERR_W(EW)) bus ();

`ifdef LDPC_3GPP_DEC_OBUF_STAT_EN
  logic [15:0] ostat_blk, ostat_fail;
`endif

  ldpc_3gpp_dec_obuf_ctrl #(.pADDR_W(AW), .pTAG_W(TW), .pERR_W(EW), .pRD_LAT(LAT)) dut (
    .iclk    (iclk),
    .ireset  (ireset),
    .iclkena (iclkena),
    .bus     (bus)
`ifdef LDPC_3GPP_DEC_OBUF_STAT_EN
    ,
    .ostat_blk  (ostat_blk),
    .ostat_fail (ostat_fail)
`endif
  );

  // Two-bank RAM with a clock-enabled read pipe of depth LAT
  logic [15:0] mem [0:(2**LW)-1];
  logic [15:0] rpipe [LAT];
  logic [15:0] wdata;
  logic [15:0] rdata;
  always @(posedge iclk) begin
    if (bus.owena) mem[bus.owaddr] <= wdata;
    if (bus.oren) begin
      rpipe[0] <= mem[bus.oraddr];
      for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
    end
  end
  assign rdata = rpipe[LAT-1];

  typedef struct {
    logic        sop;
    logic        eop;
    logic [3:0]  tag;
    logic        df;
    logic [15:0] err;
    logic [15:0] data;
  } exp_t;

  typedef struct {
    int          len;
    logic [3:0]  tag;
    logic        df;
    logic [15:0] err;
    int          exp_words;
    int          exp_lat;
    logic        exp_ordy;
  } row_t;

  exp_t q[$];
  exp_t mon_e;
  logic wb_m;
  bit   mon_en;
  bit   wr_done;
  int   n_words;
  int   n_chk;
  int   n_pass;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
  endtask

  always @(negedge iclk) begin
    if (mon_en && !ireset && iclkena && bus.irdy && bus.oval) begin
      n_words++;
      if (q.size() == 0) chk("spurious_oval", bus.oval, 1'b0);
      else begin
        mon_e = q.pop_front();
        chk("word", {bus.osop, bus.oeop, bus.otag, bus.odecfail, bus.oerr, rdata},
            {mon_e.sop, mon_e.eop, mon_e.tag, mon_e.df, mon_e.err, mon_e.data});
      end
    end
  end

  task automatic rst_checks(input string pfx);
    chk({pfx, "_ordy"}, bus.ordy, 1'b1);
    chk({pfx, "_owena"}, bus.owena, 1'b0);
    chk({pfx, "_oovf"}, bus.oovf, 1'b0);
    chk({pfx, "_oval_sop_eop"}, {bus.oval, bus.osop, bus.oeop}, 3'b000);
    chk({pfx, "_ctx"}, {bus.otag, bus.odecfail, bus.oerr}, '0);
    chk({pfx, "_oraddr"}, bus.oraddr, '0);
  endtask

  task automatic write_block(input int len, input logic [3:0] tag, input logic df,
                             input logic [15:0] err, input bit gaps);
    int n;
    int t;
    logic [15:0] d [$];
    exp_t e;
    n = (len == 0) ? 1 : len;
    t = 0;
    while (!bus.ordy && t < 5000) begin @(posedge iclk); #1; t++; end
    chk("ordy_wait", bus.ordy, 1'b1);
    for (int k = 0; k < n; k++) begin
      bus.iwrite = 1'b0;
      if (gaps) while ($urandom_range(0, 3) == 0) begin @(posedge iclk); #1; end
      bus.iwrite   = 1'b1;
      bus.iwfull   = (k == n - 1);
      bus.iwaddr   = AW'(k);
      bus.ilen     = LW'(len);
      bus.itag     = tag;
      bus.idecfail = df;
      bus.ierr     = err;
      wdata        = 16'($urandom);
      d.push_back(wdata);
      #1;
      chk("owaddr", {bus.owena, bus.owaddr}, {1'b1, wb_m, AW'(k)});
      @(posedge iclk); #1;
    end
    bus.iwrite = 1'b0;
    bus.iwfull = 1'b0;
    for (int k = 0; k < n; k++) begin
      e.sop = (k == 0); e.eop = (k == n - 1);
      e.tag = tag; e.df = df; e.err = err; e.data = d[k];
      q.push_back(e);
    end
    wb_m = ~wb_m;
  endtask

  task automatic wait_empty(input string nm);
    int t;
    t = 0;
    while (q.size() != 0 && t < 20000) begin @(posedge iclk); #1; t++; end
    chk(nm, q.size(), 0);
  endtask

  task automatic do_reset();
    mon_en = 0;
    ireset = 1'b1;
    #1;
    q.delete();
    wb_m = 1'b0;
    @(posedge iclk); #1;
    ireset = 1'b0;
    mon_en = 1;
  endtask

  row_t rows [5];
  int   w0;
  int   lat;

  initial begin
    rows[0] = '{len: 4,   tag: 4'h5, df: 1'b0, err: 16'h0000, exp_words: 4,   exp_lat: LAT + 1, exp_ordy: 1'b1};
    rows[1] = '{len: 1,   tag: 4'h3, df: 1'b1, err: 16'h0007, exp_words: 1,   exp_lat: LAT + 1, exp_ordy: 1'b1};
    rows[2] = '{len: 0,   tag: 4'h2, df: 1'b0, err: 16'h0009, exp_words: 1,   exp_lat: LAT + 1, exp_ordy: 1'b1};
    rows[3] = '{len: 6,   tag: 4'hC, df: 1'b1, err: 16'hBEEF, exp_words: 6,   exp_lat: LAT + 1, exp_ordy: 1'b1};
    rows[4] = '{len: 256, tag: 4'hF, df: 1'b0, err: 16'hFFFF, exp_words: 256, exp_lat: LAT + 1, exp_ordy: 1'b1};

    n_chk = 0; n_pass = 0; n_words = 0; mon_en = 0; wr_done = 0; wb_m = 1'b0;
    ireset = 1'b1; iclkena = 1'b1;
    bus.iwrite = 0; bus.iwfull = 0; bus.iwaddr = '0; bus.ilen = '0; bus.itag = '0;
    bus.idecfail = 0; bus.ierr = '0; bus.irdy = 0; wdata = '0;

    @(posedge iclk); #1;
    rst_checks("reset");
    iclkena = 1'b0; bus.irdy = 1'b1; #1;
    chk("oren_gated", bus.oren, 1'b0);
    iclkena = 1'b1; #1;
    chk("oren_on", bus.oren, 1'b1);
    bus.irdy = 1'b0;
    @(negedge iclk); ireset = 1'b0;
    @(posedge iclk); #1;
    mon_en = 1;

    // Single blocks with irdy held high
    bus.irdy = 1'b1;
    for (int r = 0; r < 5; r++) begin
      w0 = n_words;
      write_block(rows[r].len, rows[r].tag, rows[r].df, rows[r].err, 0);
      chk("row_ordy", bus.ordy, rows[r].exp_ordy);
      lat = 0;
      while (!bus.oval && lat < 50) begin @(posedge iclk); #1; lat++; end
      chk("row_latency", lat, rows[r].exp_lat);
      wait_empty("row_drain");
      chk("row_words", n_words - w0, rows[r].exp_words);
    end

    // irdy toggling 1010 across a 6-word block
    bus.irdy = 1'b0;
    w0 = n_words;
    write_block(6, 4'hA, 1'b0, 16'h0042, 0);
    for (int c = 0; c < 200 && q.size() != 0; c++) begin
      @(posedge iclk); #1;
      bus.irdy = ~bus.irdy;
    end
    bus.irdy = 1'b1;
    wait_empty("toggle_drain");
    chk("toggle_words", n_words - w0, 6);

    // Both banks filled with the reader stalled, then an overflow write
    bus.irdy = 1'b0;
    write_block(2, 4'h1, 1'b0, 16'h0011, 0);
    chk("one_full_ordy", bus.ordy, 1'b1);
    write_block(2, 4'h2, 1'b0, 16'h0022, 0);
    chk("both_full_ordy", bus.ordy, 1'b0);
    bus.iwrite = 1'b1; bus.iwfull = 1'b0; bus.iwaddr = '0; #1;
    chk("ovf_owena", bus.owena, 1'b0);
    @(posedge iclk); #1;
    bus.iwrite = 1'b0;
    chk("ovf_sticky", bus.oovf, 1'b1);
    bus.irdy = 1'b1;
    wait_empty("ovf_drain");
    @(posedge iclk); #1;
    chk("ovf_still_set", bus.oovf, 1'b1);

    // Asynchronous reset while word 2 is being issued
    write_block(8, 4'h7, 1'b1, 16'h0077, 0);
    for (int c = 0; c < 100 && !(bus.oval && bus.oraddr[AW-1:0] == AW'(2)); c++) @(negedge iclk);
    chk("mid_read_reached", {bus.oval, bus.oraddr[AW-1:0]}, {1'b1, AW'(2)});
    mon_en = 0;
    ireset = 1'b1; #1;
    rst_checks("midrst");
    q.delete();
    wb_m = 1'b0;
    @(posedge iclk); #1;
    ireset = 1'b0;
    mon_en = 1;
    write_block(3, 4'h9, 1'b0, 16'h1234, 0);
    wait_empty("post_reset_drain");

    // Randomized traffic with gapped writes and random user backpressure
    wr_done = 0;
    fork
      begin
        int len;
        for (int b = 0; b < 25; b++) begin
          len = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 20));
          write_block(len, 4'($urandom), 1'($urandom), 16'($urandom), 1);
        end
        wr_done = 1;
      end
      begin
        for (int c = 0; c < 30000 && !(wr_done && q.size() == 0); c++) begin
          @(posedge iclk); #1;
          bus.irdy = ($urandom_range(0, 99) < 60);
        end
        bus.irdy = 1'b1;
      end
    join
    wait_empty("random_drain");
    chk("random_no_ovf", bus.oovf, 1'b0);

`ifdef LDPC_3GPP_DEC_OBUF_STAT_EN
    do_reset();
    chk("stat_rst", {ostat_blk, ostat_fail}, 32'h0);
    bus.irdy = 1'b1;
    write_block(2, 4'h1, 1'b0, 16'h0001, 0);
    write_block(3, 4'h2, 1'b1, 16'h0002, 0);
    write_block(1, 4'h3, 1'b0, 16'h0003, 0);
    wait_empty("stat_drain");
    @(posedge iclk); #1;
    chk("stat_blk", ostat_blk, 16'd3);
    chk("stat_fail", ostat_fail, 16'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
